// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bit indices, MEM-stage handshake states
// and the MEM/WB register payload.
package pipeline_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned WB_W  = 2;
    localparam int unsigned MEM_W = 3;

    localparam int unsigned WB_REGWRITE = 0;
    localparam int unsigned WB_MEMTOREG = 1;
    localparam int unsigned MEM_WRITE   = 0;
    localparam int unsigned MEM_READ    = 1;
    localparam int unsigned MEM_BRANCH  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } hs_state_e;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [XLEN-1:0]  read_data;
        logic [XLEN-1:0]  alu_result;
        logic [REG_W-1:0] wreg;
    } memwb_t;

    localparam logic [WB_W-1:0]  WB_BUBBLE   = '0;
    localparam logic [REG_W-1:0] WREG_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '{
        wb:         WB_BUBBLE,
        read_data:  '0,
        alu_result: '0,
        wreg:       WREG_BUBBLE
    };

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ready handshake: IDLE/WAIT FSM, timeout counter and the
// holding registers that keep an outstanding access stable while stalled.
module dmem_handshake
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             we,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [WB_W-1:0]  wb,
    input  logic [REG_W-1:0] wreg,
    input  logic             ready,
    output logic             req_c,
    output logic             we_c,
    output logic [XLEN-1:0]  addr_c,
    output logic [XLEN-1:0]  wdata_c,
    output logic             stall_c,
    output logic             done_c,
    output logic             timeout_c,
    output logic             busy,
    output logic             hold_we,
    output logic [XLEN-1:0]  hold_addr,
    output logic [WB_W-1:0]  hold_wb,
    output logic [REG_W-1:0] hold_wreg
);

    hs_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hold_wdata;
    logic             at_limit;

    assign busy     = (state == ST_WAIT);
    assign at_limit = (cnt == CNT_W'(TIMEOUT));

    // Request/stall decode; in WAIT the held access is replayed and inputs ignored.
    always_comb begin
        req_c     = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        we_c      = we;
        addr_c    = addr;
        wdata_c   = wdata;
        if (!rst) begin
            req_c = 1'b0;
        end else if (state == ST_WAIT) begin
            req_c   = 1'b1;
            we_c    = hold_we;
            addr_c  = hold_addr;
            wdata_c = hold_wdata;
            if (ready) begin
                done_c = 1'b1;
            end else if (at_limit) begin
                timeout_c = 1'b1;
            end else begin
                stall_c = 1'b1;
            end
        end else if (start) begin
            req_c = 1'b1;
            if (ready) begin
                done_c = 1'b1;
            end else begin
                stall_c = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wb    <= '0;
            hold_wreg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !ready) begin
                        state      <= ST_WAIT;
                        cnt        <= CNT_W'(1);
                        hold_we    <= we;
                        hold_addr  <= addr;
                        hold_wdata <= wdata;
                        hold_wb    <= wb;
                        hold_wreg  <= wreg;
                    end
                end
                ST_WAIT: begin
                    if (ready || at_limit) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        hold_we    <= 1'b0;
                        hold_addr  <= '0;
                        hold_wdata <= '0;
                        hold_wb    <= '0;
                        hold_wreg  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues loads/stores to a variable-latency data memory,
// stalls upstream while an access is outstanding and owns the MEM/WB register.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WB_W-1:0]  inWB,
    input  logic [MEM_W-1:0] inMEM,
    input  logic [XLEN-1:0]  inALUResult,
    input  logic [XLEN-1:0]  inRegB,
    input  logic [REG_W-1:0] inRegF_wreg,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             outStall,
    output logic [WB_W-1:0]  outWB,
    output logic [XLEN-1:0]  outReadData,
    output logic [XLEN-1:0]  outALUResult,
    output logic [REG_W-1:0] outRegF_wreg,
    output logic [XLEN-1:0]  WB_regF_wd,
    output logic [REG_W-1:0] WB_rd,
    output logic             WB_regF_wr,
    output logic             outMisalign,
    output logic             outTimeoutErr
);

    logic             access;
    logic             is_store;
    logic             misaligned;
    logic             start;
    logic             done_c;
    logic             timeout_c;
    logic             busy;
    logic             hold_we;
    logic [XLEN-1:0]  hold_addr;
    logic [WB_W-1:0]  hold_wb;
    logic [REG_W-1:0] hold_wreg;
    logic             unused_branch;

    memwb_t memwb_q;
    memwb_t memwb_d;
    logic   misalign_d;
    logic   misalign_q;
    logic   timeout_err_q;

    // Branch is resolved in Execute and has no meaning here.
    assign unused_branch = inMEM[MEM_BRANCH];

    assign access     = inMEM[MEM_READ] | inMEM[MEM_WRITE];
    assign is_store   = inMEM[MEM_WRITE];
    assign misaligned = access && (inALUResult[1:0] != 2'b00);
    assign start      = access && !misaligned;

    dmem_handshake #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_hs (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .we        (is_store),
        .addr      (inALUResult),
        .wdata     (inRegB),
        .wb        (inWB),
        .wreg      (inRegF_wreg),
        .ready     (dmem_ready),
        .req_c     (dmem_req),
        .we_c      (dmem_we),
        .addr_c    (dmem_addr),
        .wdata_c   (dmem_wdata),
        .stall_c   (outStall),
        .done_c    (done_c),
        .timeout_c (timeout_c),
        .busy      (busy),
        .hold_we   (hold_we),
        .hold_addr (hold_addr),
        .hold_wb   (hold_wb),
        .hold_wreg (hold_wreg)
    );

    // MEM/WB next value: bubble unless an op completes (or needs no memory) this cycle.
    always_comb begin
        memwb_d    = MEMWB_BUBBLE;
        misalign_d = 1'b0;
        if (busy) begin
            if (done_c) begin
                memwb_d.wb         = hold_wb;
                memwb_d.read_data  = hold_we ? XLEN'(0) : dmem_rdata;
                memwb_d.alu_result = hold_addr;
                memwb_d.wreg       = hold_wreg;
            end
        end else if (misaligned) begin
            misalign_d = 1'b1;
        end else if (!access || done_c) begin
            memwb_d.wb         = inWB;
            memwb_d.read_data  = (access && !is_store) ? dmem_rdata : XLEN'(0);
            memwb_d.alu_result = inALUResult;
            memwb_d.wreg       = inRegF_wreg;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            memwb_q       <= MEMWB_BUBBLE;
            misalign_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            memwb_q       <= memwb_d;
            misalign_q    <= misalign_d;
            timeout_err_q <= timeout_err_q | timeout_c;
        end
    end

    assign outWB         = memwb_q.wb;
    assign outReadData   = memwb_q.read_data;
    assign outALUResult  = memwb_q.alu_result;
    assign outRegF_wreg  = memwb_q.wreg;
    assign outMisalign   = misalign_q;
    assign outTimeoutErr = timeout_err_q;

    assign WB_regF_wd = memwb_q.wb[WB_MEMTOREG] ? memwb_q.read_data : memwb_q.alu_result;
    assign WB_rd      = memwb_q.wreg;
    assign WB_regF_wr = memwb_q.wb[WB_REGWRITE];

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table-driven single-cycle ops plus
// hand-written wait, timeout and reset sequences, checked through a scoreboard.
module tb_memory_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  inWB;
    logic [2:0]  inMEM;
    logic [31:0] inALUResult;
    logic [31:0] inRegB;
    logic [4:0]  inRegF_wreg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        outStall;
    logic [1:0]  outWB;
    logic [31:0] outReadData;
    logic [31:0] outALUResult;
    logic [4:0]  outRegF_wreg;
    logic [31:0] WB_regF_wd;
    logic [4:0]  WB_rd;
    logic        WB_regF_wr;
    logic        outMisalign;
    logic        outTimeoutErr;

    int   checks;
    int   errors;
    logic exp_err;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] alu;
        logic [31:0] regb;
        logic [4:0]  wreg;
        logic        ready;
        logic [31:0] rdata;
        logic        x_req;
        logic        x_we;
        logic [1:0]  x_wb;
        logic [31:0] x_rd;
        logic [31:0] x_alu;
        logic [4:0]  x_wreg;
        logic        x_mis;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    memory_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .inWB          (inWB),
        .inMEM         (inMEM),
        .inALUResult   (inALUResult),
        .inRegB        (inRegB),
        .inRegF_wreg   (inRegF_wreg),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .outStall      (outStall),
        .outWB         (outWB),
        .outReadData   (outReadData),
        .outALUResult  (outALUResult),
        .outRegF_wreg  (outRegF_wreg),
        .WB_regF_wd    (WB_regF_wd),
        .WB_rd         (WB_rd),
        .WB_regF_wr    (WB_regF_wr),
        .outMisalign   (outMisalign),
        .outTimeoutErr (outTimeoutErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] alu,
                         input logic [31:0] regb, input logic [4:0] wreg, input logic ready,
                         input logic [31:0] rdata);
        inWB        = wb;
        inMEM       = mem;
        inALUResult = alu;
        inRegB      = regb;
        inRegF_wreg = wreg;
        dmem_ready  = ready;
        dmem_rdata  = rdata;
    endtask

    task automatic expect_memwb(input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] alu,
                                input logic [4:0] wreg, input logic mis);
        exp_t e;
        e.wb = wb; e.rd = rd; e.alu = alu; e.wreg = wreg; e.mis = mis;
        sb.push_back(e);
    endtask

    // Pop the oldest expected MEM/WB result and compare all write-back outputs.
    task automatic check_memwb(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty actual=0 required=1", name);
            return;
        end
        e = sb.pop_front();
        chk({name, " outWB"},         32'(outWB),         32'(e.wb));
        chk({name, " outReadData"},   outReadData,        e.rd);
        chk({name, " outALUResult"},  outALUResult,       e.alu);
        chk({name, " outRegF_wreg"},  32'(outRegF_wreg),  32'(e.wreg));
        chk({name, " WB_regF_wd"},    WB_regF_wd,         e.wb[1] ? e.rd : e.alu);
        chk({name, " WB_rd"},         32'(WB_rd),         32'(e.wreg));
        chk({name, " WB_regF_wr"},    32'(WB_regF_wr),    32'(e.wb[0]));
        chk({name, " outMisalign"},   32'(outMisalign),   32'(e.mis));
        chk({name, " outTimeoutErr"}, 32'(outTimeoutErr), 32'(exp_err));
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        drive(v.wb, v.mem, v.alu, v.regb, v.wreg, v.ready, v.rdata);
        expect_memwb(v.x_wb, v.x_rd, v.x_alu, v.x_wreg, v.x_mis);
        @(posedge clk);
        chk({name, " req"},   32'(dmem_req), 32'(v.x_req));
        chk({name, " stall"}, 32'(outStall), 32'(0));
        if (v.x_req) begin
            chk({name, " we"},   32'(dmem_we), 32'(v.x_we));
            chk({name, " addr"}, dmem_addr,    v.alu);
            if (v.x_we) chk({name, " wdata"}, dmem_wdata, v.regb);
        end
        @(negedge clk); #1;
        check_memwb(name);
    endtask

    // Aligned access that completes after `waits` stall cycles; inputs are scrambled while waiting.
    task automatic wait_access(input logic st, input logic [1:0] wb, input logic [31:0] alu,
                               input logic [31:0] regb, input logic [4:0] wreg, input int waits,
                               input logic [31:0] rdata, input string name);
        int stalls;
        stalls = 0;
        drive(wb, st ? 3'b001 : 3'b010, alu, regb, wreg, 1'b0, 32'h0BAD_0BAD);
        expect_memwb(wb, st ? 32'h0 : rdata, alu, wreg, 1'b0);
        for (int i = 0; i <= waits; i++) begin
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 32'h0BAD_0BAD;
            @(posedge clk);
            chk($sformatf("%s c%0d req", name, i),   32'(dmem_req), 32'(1));
            chk($sformatf("%s c%0d addr", name, i),  dmem_addr,     alu);
            chk($sformatf("%s c%0d we", name, i),    32'(dmem_we),  32'(st));
            if (st) chk($sformatf("%s c%0d wdata", name, i), dmem_wdata, regb);
            if (outStall) stalls++;
            @(negedge clk); #1;
            if (i < waits) begin
                chk($sformatf("%s c%0d bubble_wb", name, i),   32'(outWB),        32'(0));
                chk($sformatf("%s c%0d bubble_wreg", name, i), 32'(outRegF_wreg), 32'(0));
                drive(2'b11, 3'b010, 32'hDEAD_0003, ~regb, 5'd31, 1'b0, 32'h0BAD_0BAD);
            end
        end
        check_memwb(name);
        chk({name, " stall_cycles"}, 32'(stalls), 32'(waits));
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        chk({name, " req_dropped"}, 32'(dmem_req), 32'(0));
        @(negedge clk); #1;
    endtask

    initial begin
        int stalls;
        checks  = 0;
        errors  = 0;
        exp_err = 1'b0;

        //        wb     mem     alu           regb          wreg  rdy   rdata         req   we    x_wb   x_rd          x_alu         x_wreg mis
        vecs[0] = '{2'b11, 3'b010, 32'h0000_0040, 32'h0,        5'd5,  1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'h0000_0040, 5'd5,  1'b0};
        vecs[1] = '{2'b01, 3'b000, 32'h0000_0007, 32'h0,        5'd9,  1'b1, 32'h0000_0055, 1'b0, 1'b0, 2'b01, 32'h0,         32'h0000_0007, 5'd9,  1'b0};
        vecs[2] = '{2'b00, 3'b001, 32'h0000_0084, 32'h0000_1234, 5'd3,  1'b1, 32'h0000_AAAA, 1'b1, 1'b1, 2'b00, 32'h0,         32'h0000_0084, 5'd3,  1'b0};
        vecs[3] = '{2'b00, 3'b011, 32'h0000_0088, 32'h0000_0077, 5'd4,  1'b1, 32'h0000_BBBB, 1'b1, 1'b1, 2'b00, 32'h0,         32'h0000_0088, 5'd4,  1'b0};
        vecs[4] = '{2'b11, 3'b010, 32'h0000_0042, 32'h0,        5'd5,  1'b1, 32'h1111_2222, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         5'd0,  1'b1};
        vecs[5] = '{2'b00, 3'b001, 32'h0000_0081, 32'h0000_5678, 5'd2,  1'b1, 32'h0,        1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         5'd0,  1'b1};
        vecs[6] = '{2'b10, 3'b100, 32'h0000_0100, 32'h0,        5'd31, 1'b1, 32'h3333_4444, 1'b0, 1'b0, 2'b10, 32'h0,         32'h0000_0100, 5'd31, 1'b0};
        vecs[7] = '{2'b01, 3'b010, 32'h0000_000C, 32'h0,        5'd7,  1'b1, 32'h0000_1111, 1'b1, 1'b0, 2'b01, 32'h0000_1111, 32'h0000_000C, 5'd7,  1'b0};

        rst = 1'b0;
        drive(2'b11, 3'b000, 32'h0000_0010, 32'h0, 5'd1, 1'b1, 32'hFFFF_FFFF);
        #12;
        chk("reset req",        32'(dmem_req),      32'(0));
        chk("reset stall",      32'(outStall),      32'(0));
        chk("reset outWB",      32'(outWB),         32'(0));
        chk("reset readdata",   outReadData,        32'h0);
        chk("reset aluresult",  outALUResult,       32'h0);
        chk("reset wreg",       32'(outRegF_wreg),  32'(0));
        chk("reset misalign",   32'(outMisalign),   32'(0));
        chk("reset timeouterr", 32'(outTimeoutErr), 32'(0));
        rst = 1'b1;
        @(negedge clk); #1;
        sb.delete();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        wait_access(1'b1, 2'b00, 32'h0000_0080, 32'h0000_1234, 5'd2, 3, 32'h0, "store3");
        wait_access(1'b0, 2'b11, 32'h0000_0200, 32'h0, 5'd12, 2, 32'hCAFE_F00D, "load2");

        // Load that never completes: abandoned after the full stall budget.
        stalls = 0;
        drive(2'b11, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b0, 32'h0);
        expect_memwb(2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i <= int'(TIMEOUT); i++) begin
            @(posedge clk);
            chk($sformatf("timeout c%0d req", i), 32'(dmem_req), 32'(1));
            if (outStall) stalls++;
            @(negedge clk); #1;
            if (i < int'(TIMEOUT)) chk($sformatf("timeout c%0d err", i), 32'(outTimeoutErr), 32'(0));
        end
        exp_err = 1'b1;
        check_memwb("timeout");
        chk("timeout stall_cycles", 32'(stalls), 32'(TIMEOUT));
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        chk("timeout req_dropped", 32'(dmem_req), 32'(0));
        chk("timeout stall_low",   32'(outStall), 32'(0));
        @(negedge clk); #1;
        apply_vec(vecs[1], "sticky_nonmem");

        // Reset while waiting on a load.
        drive(2'b11, 3'b010, 32'h0000_0400, 32'h0, 5'd6, 1'b0, 32'h0);
        @(posedge clk);
        chk("rstwait stall0", 32'(outStall), 32'(1));
        @(negedge clk); #1;
        @(posedge clk);
        chk("rstwait stall1", 32'(outStall), 32'(1));
        @(negedge clk); #1;
        #2 rst = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("rstwait req",        32'(dmem_req),      32'(0));
        chk("rstwait stall",      32'(outStall),      32'(0));
        chk("rstwait outWB",      32'(outWB),         32'(0));
        chk("rstwait readdata",   outReadData,        32'h0);
        chk("rstwait aluresult",  outALUResult,       32'h0);
        chk("rstwait wreg",       32'(outRegF_wreg),  32'(0));
        chk("rstwait misalign",   32'(outMisalign),   32'(0));
        chk("rstwait timeouterr", 32'(outTimeoutErr), 32'(0));
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk); #1;

        wait_access(1'b0, 2'b11, 32'h0000_0500, 32'h0, 5'd8, 1, 32'h1357_9BDF, "post_reset");
        apply_vec(vecs[0], "post_reset_zero_wait");

        chk("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
